// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - RV32M divide decode constants and sequencer state type
package core_pkg;
  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
endpackage

// File: rtl/div_iter_core.sv
// rtl/div_iter_core.sv - unsigned restoring divider datapath, one quotient bit per step
module div_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);
  logic [XLEN-1:0] quo_q, rem_q, div_q;
  logic [XLEN:0]   shifted, diff;

  // Trial subtract is one bit wider so its MSB is the borrow/sign.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, div_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
    end else if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      div_q <= divisor_i;
    end else if (step_i) begin
      if (diff[XLEN]) begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end else begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
endmodule

// File: rtl/muldiv_div_controller.sv
// rtl/muldiv_div_controller.sv - multi-cycle DIV/DIVU/REM/REMU sequencer with pipeline stall
module muldiv_div_controller
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [6:0]      opcode_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            is_div_o
);
  localparam int CNT_W = $clog2(XLEN);

  div_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            rem_sel_q, neg_q_q, neg_r_q, valid_q;
  logic [XLEN-1:0] result_q;

  logic            accept, is_signed, a_neg, b_neg, div_zero, sgn_ovf;
  logic [XLEN-1:0] abs_a, abs_b, quo, rem, fix_q, fix_r;

  assign is_div_o  = (opcode_i == OPCODE_R) && (funct7_i == FUNCT7_MULDIV) && funct3_i[2];
  assign accept    = (state_q == IDLE) && start_i && is_div_o && !flush_i;
  assign is_signed = !funct3_i[0];
  assign a_neg     = is_signed && op_a_i[XLEN-1];
  assign b_neg     = is_signed && op_b_i[XLEN-1];
  assign abs_a     = a_neg ? -op_a_i : op_a_i;
  assign abs_b     = b_neg ? -op_b_i : op_b_i;
  assign div_zero  = (op_b_i == '0);
  assign sgn_ovf   = is_signed && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
  assign fix_q     = neg_q_q ? -quo : quo;
  assign fix_r     = neg_r_q ? -rem : rem;

  div_iter_core #(.XLEN(XLEN)) u_core (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (accept),
    .step_i      (state_q == CALC),
    .dividend_i  (abs_a),
    .divisor_i   (abs_b),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i && is_div_o) begin
              rem_sel_q <= funct3_i[1];
              neg_q_q   <= a_neg ^ b_neg;
              neg_r_q   <= a_neg;
              // RISC-V defines these results instead of trapping; no iteration needed.
              if (div_zero) begin
                result_q <= funct3_i[1] ? op_a_i : '1;
                valid_q  <= 1'b1;
                state_q  <= DONE;
              end else if (sgn_ovf) begin
                result_q <= funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                valid_q  <= 1'b1;
                state_q  <= DONE;
              end else begin
                cnt_q   <= CNT_W'(XLEN - 1);
                state_q <= CALC;
              end
            end
          end
          CALC: begin
            if (cnt_q == '0) state_q <= FIX;
            else             cnt_q   <= cnt_q - CNT_W'(1);
          end
          FIX: begin
            result_q <= rem_sel_q ? fix_r : fix_q;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // A flush arriving in DONE must still swallow the already-registered pulse.
  assign valid_o  = valid_q && !flush_i;
  assign result_o = result_q;
  assign stall_o  = accept || (state_q == CALC) || (state_q == FIX);
endmodule
